register_readout: RTL and testbench

REGISTER_READOUT -- requirements
Module: RegisterReadout

---
 rtl/register_readout.sv | 124 ++++++++++++
 tb/tb_register_readout.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/register_readout.sv
// Register readout serializer: fetches a register byte at the pointer address and
// shifts it out MSB first, optionally bursting through consecutive addresses.
//
// state | meaning
// IDLE  | waiting for ReadStart, SDO held low
// FETCH | one cycle; captures RegData for the current RegAddr and presents its MSB
// SHIFT | each ShiftEn advances one bit; the last pulse completes the byte
module register_readout #(
    parameter int AddressWidth = 8,
    parameter int DataWidth    = 8
) (
    input  logic                    CLK,
    input  logic                    _RST,
    input  logic [AddressWidth-1:0] AddressBus,
    input  logic [DataWidth-1:0]    RegData,
    input  logic                    ReadStart,
    input  logic                    ShiftEn,
    input  logic                    Burst,
    input  logic                    Abort,
    output logic [AddressWidth-1:0] RegAddr,
    output logic                    SDO,
    output logic [AddressWidth-1:0] NewAddress,
    output logic                    AddressLoad,
    output logic                    ByteDone,
    output logic                    Busy
);

    localparam int CountWidth = (DataWidth > 1) ? $clog2(DataWidth) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t                  state, stateNext;
    logic [DataWidth-1:0]    shiftReg, shiftNext;
    logic [CountWidth-1:0]   bitCount, countNext;
    logic [AddressWidth-1:0] regAddrNext, newAddrNext, addrPlusOne;
    logic                    sdoNext, addrLoadNext, byteDoneNext;

    assign addrPlusOne = RegAddr + AddressWidth'(1);
    assign Busy        = (state != IDLE);

    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            state       <= IDLE;
            shiftReg    <= '0;
            bitCount    <= '0;
            RegAddr     <= '0;
            NewAddress  <= '0;
            SDO         <= 1'b0;
            AddressLoad <= 1'b0;
            ByteDone    <= 1'b0;
        end else begin
            state       <= stateNext;
            shiftReg    <= shiftNext;
            bitCount    <= countNext;
            RegAddr     <= regAddrNext;
            NewAddress  <= newAddrNext;
            SDO         <= sdoNext;
            AddressLoad <= addrLoadNext;
            ByteDone    <= byteDoneNext;
        end
    end

    always_comb begin
        stateNext    = state;
        shiftNext    = shiftReg;
        countNext    = bitCount;
        regAddrNext  = RegAddr;
        newAddrNext  = NewAddress;
        sdoNext      = SDO;
        addrLoadNext = 1'b0;
        byteDoneNext = 1'b0;

        // Abort wins over everything and leaves both address outputs untouched
        if (Abort) begin
            stateNext = IDLE;
            sdoNext   = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    sdoNext = 1'b0;
                    if (ReadStart) begin
                        regAddrNext = AddressBus;
                        stateNext   = FETCH;
                    end
                end
                FETCH: begin
                    shiftNext = RegData;
                    countNext = CountWidth'(DataWidth - 1);
                    sdoNext   = RegData[DataWidth-1];
                    stateNext = SHIFT;
                end
                SHIFT: begin
                    if (ShiftEn) begin
                        if (bitCount != '0) begin
                            shiftNext = shiftReg << 1;
                            sdoNext   = shiftNext[DataWidth-1];
                            countNext = bitCount - CountWidth'(1);
                        end else begin
                            byteDoneNext = 1'b1;
                            addrLoadNext = 1'b1;
                            regAddrNext  = addrPlusOne;
                            newAddrNext  = addrPlusOne;
                            if (Burst) begin
                                stateNext = FETCH;
                            end else begin
                                stateNext = IDLE;
                                sdoNext   = 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    stateNext = IDLE;
                    sdoNext   = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_register_readout.sv
// Bench for register_readout: table of read transfers checked through an SDO
// scoreboard, plus abort, mid-byte reset and ignored-input sequences.
module tb_register_readout;

    logic       clk;
    logic       rstN;
    logic [7:0] addressBus;
    logic [7:0] regData;
    logic       readStart;
    logic       shiftEn;
    logic       burst;
    logic       abort;
    logic [7:0] regAddr;
    logic       sdo;
    logic [7:0] newAddress;
    logic       addressLoad;
    logic       byteDone;
    logic       busy;

    logic [7:0] regFile [256];
    logic       sdoQ [$];

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] d0;
        logic [7:0] d1;
        int         nBytes;
        logic [7:0] e0;
        logic [7:0] e1;
    } vec_t;

    vec_t vecs [5];

    assign regData = regFile[regAddr];

    register_readout #(.AddressWidth(8), .DataWidth(8)) dut (
        .CLK        (clk),
        ._RST       (rstN),
        .AddressBus (addressBus),
        .RegData    (regData),
        .ReadStart  (readStart),
        .ShiftEn    (shiftEn),
        .Burst      (burst),
        .Abort      (abort),
        .RegAddr    (regAddr),
        .SDO        (sdo),
        .NewAddress (newAddress),
        .AddressLoad(addressLoad),
        .ByteDone   (byteDone),
        .Busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkSdo(input string name);
        logic e;
        if (sdoQ.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: scoreboard empty, got sdo %0b", name, sdo);
        end else begin
            e = sdoQ.pop_front();
            check(name, {31'd0, sdo}, {31'd0, e});
        end
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_regaddr"}, {24'd0, regAddr}, 32'd0);
        check({tag, "_newaddr"}, {24'd0, newAddress}, 32'd0);
        check({tag, "_sdo"}, {31'd0, sdo}, 32'd0);
        check({tag, "_addrload"}, {31'd0, addressLoad}, 32'd0);
        check({tag, "_bytedone"}, {31'd0, byteDone}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic startRead(input logic [7:0] addr);
        addressBus = addr;
        readStart  = 1'b1;
        tick();
        readStart  = 1'b0;
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_regaddr", {24'd0, regAddr}, {24'd0, addr});
    endtask

    task automatic runTransfer(input logic [7:0] addr, input logic [7:0] d0, input logic [7:0] d1,
                               input int nBytes, input logic [7:0] e0, input logic [7:0] e1);
        logic [7:0] a1;
        logic [7:0] d;
        logic [7:0] e;
        a1 = addr + 8'd1;
        regFile[addr] = d0;
        regFile[a1]   = d1;
        startRead(addr);
        for (int b = 0; b < nBytes; b++) begin
            d = (b == 0) ? d0 : d1;
            e = (b == 0) ? e0 : e1;
            sdoQ.push_back(d[7]);
            tick();
            checkSdo("fetch_msb");
            for (int p = 1; p <= 8; p++) begin
                shiftEn = 1'b1;
                burst   = (b < nBytes - 1);
                if (p == 5) begin
                    readStart  = 1'b1;
                    addressBus = addr ^ 8'h55;
                end
                if (p < 8) sdoQ.push_back(d[7-p]);
                tick();
                shiftEn   = 1'b0;
                readStart = 1'b0;
                if (p < 8) begin
                    checkSdo("shift_bit");
                    check("mid_bytedone", {31'd0, byteDone}, 32'd0);
                    if (p == 5) check("ignored_start", {24'd0, regAddr}, {24'd0, (b == 0) ? addr : a1});
                    if (p == 3) begin
                        sdoQ.push_back(d[4]);
                        tick();
                        checkSdo("hold_bit");
                    end
                end else begin
                    check("bytedone", {31'd0, byteDone}, 32'd1);
                    check("addrload", {31'd0, addressLoad}, 32'd1);
                    check("newaddr", {24'd0, newAddress}, {24'd0, e});
                    check("regaddr_inc", {24'd0, regAddr}, {24'd0, e});
                    check("busy_after_byte", {31'd0, busy}, (b < nBytes - 1) ? 32'd1 : 32'd0);
                    if (b == nBytes - 1) check("sdo_idle", {31'd0, sdo}, 32'd0);
                end
            end
        end
        burst = 1'b0;
        tick();
        check("addrload_pulse", {31'd0, addressLoad}, 32'd0);
        check("bytedone_pulse", {31'd0, byteDone}, 32'd0);
        check("newaddr_hold", {24'd0, newAddress}, {24'd0, (nBytes == 1) ? e0 : e1});
    endtask

    initial begin
        vecs[0] = '{8'h10, 8'hA5, 8'h00, 1, 8'h11, 8'h00};
        vecs[1] = '{8'h20, 8'h3C, 8'hC3, 2, 8'h21, 8'h22};
        vecs[2] = '{8'hFF, 8'h5A, 8'h00, 1, 8'h00, 8'h00};
        vecs[3] = '{8'hFE, 8'h00, 8'hFF, 2, 8'hFF, 8'h00};
        vecs[4] = '{8'h7F, 8'h81, 8'h42, 2, 8'h80, 8'h81};

        for (int i = 0; i < 256; i++) regFile[i] = 8'h00;
        rstN       = 1'b0;
        addressBus = 8'h00;
        readStart  = 1'b0;
        shiftEn    = 1'b0;
        burst      = 1'b0;
        abort      = 1'b0;

        #12;
        checkAllZero("reset");
        @(negedge clk);
        rstN = 1'b1;
        tick();
        tick();
        check("post_reset_idle", {31'd0, busy}, 32'd0);

        for (int v = 0; v < 5; v++) begin
            runTransfer(vecs[v].addr, vecs[v].d0, vecs[v].d1, vecs[v].nBytes, vecs[v].e0, vecs[v].e1);
        end

        // abort after three shift pulses
        regFile[8'h40] = 8'h96;
        startRead(8'h40);
        sdoQ.push_back(1'b1);
        tick();
        checkSdo("abort_fetch");
        for (int p = 1; p <= 3; p++) begin
            shiftEn = 1'b1;
            tick();
        end
        shiftEn = 1'b0;
        check("abort_pre_sdo", {31'd0, sdo}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_sdo", {31'd0, sdo}, 32'd0);
        check("abort_addrload", {31'd0, addressLoad}, 32'd0);
        check("abort_bytedone", {31'd0, byteDone}, 32'd0);
        check("abort_newaddr", {24'd0, newAddress}, 32'h81);
        check("abort_regaddr", {24'd0, regAddr}, 32'h40);

        // ShiftEn while idle must do nothing
        shiftEn = 1'b1;
        tick();
        tick();
        shiftEn = 1'b0;
        check("idle_shift_busy", {31'd0, busy}, 32'd0);
        check("idle_shift_sdo", {31'd0, sdo}, 32'd0);
        check("idle_shift_regaddr", {24'd0, regAddr}, 32'h40);
        check("idle_shift_addrload", {31'd0, addressLoad}, 32'd0);

        // asynchronous reset in the middle of a byte
        regFile[8'h50] = 8'hFF;
        startRead(8'h50);
        tick();
        for (int p = 1; p <= 5; p++) begin
            shiftEn = 1'b1;
            tick();
        end
        shiftEn = 1'b0;
        check("midreset_pre_sdo", {31'd0, sdo}, 32'd1);
        #2;
        rstN = 1'b0;
        #1;
        checkAllZero("midreset");
        @(negedge clk);
        rstN = 1'b1;
        tick();
        check("midreset_idle", {31'd0, busy}, 32'd0);
        runTransfer(8'h50, 8'h6B, 8'h00, 1, 8'h51, 8'h00);

        check("scoreboard_drained", sdoQ.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
